// File: rtl/axis_maxpool_engine.sv
// Optional 2x2/stride-2 signed max-pool on an AXI-Stream of UNITS-row columns, two pooled columns per output beat.
// Latency 1 from the emitting handshake; input stalls only while a held output beat is not taken.
module axis_maxpool_engine #(
  parameter int WORD_WIDTH  = 8,
  parameter int UNITS       = 4,
  parameter int GROUPS      = 2,
  parameter int COPIES      = 2,
  parameter int TUSER_WIDTH = 4,
  parameter int I_IS_MAX    = 0
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0]   s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]                      s_axis_tuser,
  input  logic                                        s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0]   m_axis_tdata,
  output logic                                        m_axis_tlast
);
  localparam int NS = COPIES * GROUPS;
  localparam int HU = UNITS / 2;
  localparam int DW = NS * UNITS * WORD_WIDTH;
  localparam int HW = NS * HU * WORD_WIDTH;

  function automatic logic [WORD_WIDTH-1:0] smax(input logic [WORD_WIDTH-1:0] a,
                                                 input logic [WORD_WIDTH-1:0] b);
    smax = ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [1:0]    phase_q, phase_d;
  logic          sop_q, sop_d;
  logic          mode_q, mode_d;
  logic [HW-1:0] hold_a_q, hold_a_d;
  logic [HW-1:0] hold_p0_q, hold_p0_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [DW-1:0] m_data_q, m_data_d;

  logic [HW-1:0] vcol, vmax_a, pool_p0, pool_p1;
  logic [DW-1:0] pool_out;
  logic          s_hs, cur_mode, emit;
  logic          unused_tuser;

  assign unused_tuser  = ^s_axis_tuser;
  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

  // Vertical pair max per (copy, group), then horizontal max against the held column;
  // pooled columns land in the low and high halves of each UNITS-word slot.
  for (genvar s = 0; s < NS; s++) begin : g_slot
    for (genvar u = 0; u < HU; u++) begin : g_col
      localparam int K = s * HU + u;
      assign vcol[K*WORD_WIDTH +: WORD_WIDTH] =
        smax(s_axis_tdata[(s*UNITS+2*u)*WORD_WIDTH +: WORD_WIDTH],
             s_axis_tdata[(s*UNITS+2*u+1)*WORD_WIDTH +: WORD_WIDTH]);
      assign vmax_a[K*WORD_WIDTH +: WORD_WIDTH] =
        smax(hold_a_q[K*WORD_WIDTH +: WORD_WIDTH], vcol[K*WORD_WIDTH +: WORD_WIDTH]);
      assign pool_out[(s*UNITS+u)*WORD_WIDTH +: WORD_WIDTH]    = pool_p0[K*WORD_WIDTH +: WORD_WIDTH];
      assign pool_out[(s*UNITS+HU+u)*WORD_WIDTH +: WORD_WIDTH] = pool_p1[K*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    phase_d   = phase_q;
    sop_d     = sop_q;
    mode_d    = mode_q;
    hold_a_d  = hold_a_q;
    hold_p0_d = hold_p0_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    pool_p0   = '0;
    pool_p1   = '0;
    emit      = 1'b0;
    s_hs      = s_axis_tvalid && s_axis_tready;
    cur_mode  = sop_q ? s_axis_tuser[I_IS_MAX] : mode_q;

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    if (s_hs) begin
      sop_d  = s_axis_tlast;
      mode_d = cur_mode;
      if (!cur_mode) begin
        m_valid_d = 1'b1;
        m_data_d  = s_axis_tdata;
        m_last_d  = s_axis_tlast;
      end else begin
        phase_d = phase_q + 2'd1;
        // A tlast before phase 3 flushes a short window, zero-filling any missing column.
        unique case (phase_q)
          2'd0: begin
            hold_a_d = vcol;
            pool_p0  = vcol;
            emit     = s_axis_tlast;
          end
          2'd1: begin
            hold_p0_d = vmax_a;
            pool_p0   = vmax_a;
            emit      = s_axis_tlast;
          end
          2'd2: begin
            hold_a_d = vcol;
            pool_p0  = hold_p0_q;
            pool_p1  = vcol;
            emit     = s_axis_tlast;
          end
          default: begin
            pool_p0 = hold_p0_q;
            pool_p1 = vmax_a;
            emit    = 1'b1;
          end
        endcase
        if (emit) begin
          phase_d   = 2'd0;
          m_valid_d = 1'b1;
          m_data_d  = pool_out;
          m_last_d  = s_axis_tlast;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q   <= 2'd0;
      sop_q     <= 1'b1;
      mode_q    <= 1'b0;
      hold_a_q  <= '0;
      hold_p0_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      sop_q     <= sop_d;
      mode_q    <= mode_d;
      hold_a_q  <= hold_a_d;
      hold_p0_q <= hold_p0_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end
endmodule

// File: tb/tb_axis_maxpool_engine.sv
// Scoreboard bench for axis_maxpool_engine: directed pass/pool/tail/reset cases plus random packets under backpressure.
module tb_axis_maxpool_engine;
  localparam int W = 8, UNITS = 4, GROUPS = 2, COPIES = 2, TUW = 4;
  localparam int NS = COPIES * GROUPS, HU = UNITS / 2, DW = NS * UNITS * W;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [TUW-1:0] s_tuser = '0;
  logic          m_tvalid, m_tready = 1'b1, m_tlast;
  logic [DW-1:0] m_tdata;

  axis_maxpool_engine #(.WORD_WIDTH(W), .UNITS(UNITS), .GROUPS(GROUPS), .COPIES(COPIES),
                        .TUSER_WIDTH(TUW), .I_IS_MAX(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast));

  always #5 aclk = ~aclk;

  int n_vec = 0, n_err = 0;
  logic [DW:0] exp_q[$];
  bit use_model = 1'b0, gen_done = 1'b0;

  // Reference model state, kept in plain integers
  bit mdl_sop = 1'b1, mdl_mode = 1'b0;
  int mdl_phase = 0;
  int mdl_a[NS*HU], mdl_p0[NS*HU];

  function automatic logic [DW-1:0] mk(input int w0, input int w1, input int w2, input int w3);
    logic [DW-1:0] r;
    r = '0;
    for (int s = 0; s < NS; s++) begin
      r[(s*UNITS+0)*W +: W] = w0[W-1:0];
      r[(s*UNITS+1)*W +: W] = w1[W-1:0];
      r[(s*UNITS+2)*W +: W] = w2[W-1:0];
      r[(s*UNITS+3)*W +: W] = w3[W-1:0];
    end
    return r;
  endfunction

  function automatic int wd(input logic [DW-1:0] d, input int idx);
    logic signed [W-1:0] b;
    b = d[idx*W +: W];
    return int'(b);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    mdl_sop = 1'b1; mdl_mode = 1'b0; mdl_phase = 0;
    for (int k = 0; k < NS*HU; k++) begin mdl_a[k] = 0; mdl_p0[k] = 0; end
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic [TUW-1:0] u, input logic l);
    int v[NS*HU];
    int p1[NS*HU];
    bit emit;
    logic [DW-1:0] o;
    if (mdl_sop) mdl_mode = u[0];
    mdl_sop = l;
    if (!mdl_mode) begin
      if (use_model) exp_q.push_back({l, d});
      return;
    end
    for (int k = 0; k < NS*HU; k++) begin
      v[k]  = imax(wd(d, (k/HU)*UNITS + 2*(k%HU)), wd(d, (k/HU)*UNITS + 2*(k%HU) + 1));
      p1[k] = 0;
    end
    emit = l;
    for (int k = 0; k < NS*HU; k++) begin
      case (mdl_phase)
        0: begin mdl_a[k] = v[k]; mdl_p0[k] = v[k]; end
        1: mdl_p0[k] = imax(mdl_a[k], v[k]);
        2: begin mdl_a[k] = v[k]; p1[k] = v[k]; end
        default: begin p1[k] = imax(mdl_a[k], v[k]); emit = 1'b1; end
      endcase
    end
    if (emit) begin
      o = '0;
      for (int k = 0; k < NS*HU; k++) begin
        o[((k/HU)*UNITS + (k%HU))*W +: W]      = mdl_p0[k][W-1:0];
        o[((k/HU)*UNITS + HU + (k%HU))*W +: W] = p1[k][W-1:0];
      end
      if (use_model) exp_q.push_back({l, o});
      mdl_phase = 0;
    end else begin
      mdl_phase = mdl_phase + 1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [TUW-1:0] u, input logic l);
    int t = 0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && t < 200) begin @(negedge aclk); t++; end
    if (!s_tready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: s_axis_tready=%b, required 1", s_tready);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    model_beat(d, u, l);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(negedge aclk); t++; end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk); #1;
  endtask

  // Output monitor: scoreboard pop on each output handshake, hold/stall rules while blocked
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic prev_l;
  logic [DW:0] e;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall) begin
        n_vec++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l) begin
          n_err++;
          $display("FAIL hold_stable: got v=%b l=%b d=%h, required v=1 l=%b d=%h", m_tvalid, m_tlast, m_tdata, prev_l, prev_d);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b0) begin
        n_vec++;
        if (s_tready !== 1'b0) begin
          n_err++;
          $display("FAIL s_ready_blocked: s_axis_tready=%b, required 0", s_tready);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got l=%b d=%h, required no beat", m_tlast, m_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            n_err++;
            $display("FAIL out_beat: got l=%b d=%h, required l=%b d=%h", m_tlast, m_tdata, e[DW], e[DW-1:0]);
          end
        end
      end
      prev_stall = (m_tvalid === 1'b1 && m_tready === 1'b0);
      prev_d = m_tdata;
      prev_l = m_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk); #1;
    n_vec++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h, required all 0", m_tvalid, m_tlast, m_tdata);
    end
    n_vec++;
    if (s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: s_axis_tready=%b, required 1", s_tready);
    end
    aresetn = 1'b1;
    model_reset();
    @(posedge aclk); #1;
  endtask

  task automatic test_pass();
    logic [DW-1:0] b[3];
    b[0] = mk(1, 2, 3, 4); b[1] = mk(5, 6, 7, 8); b[2] = mk(9, 10, 11, 12);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({(i == 2), b[i]});
      // later-beat is_max must not switch the packet into pooling
      send_beat(b[i], (i == 0) ? 4'b0000 : 4'b0001, (i == 2));
      n_vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== b[i] || m_tlast !== (i == 2)) begin
        n_err++;
        $display("FAIL pass_latency[%0d]: got v=%b l=%b d=%h, required v=1 l=%b d=%h", i, m_tvalid, m_tlast, m_tdata, (i == 2), b[i]);
      end
    end
    drain();
  endtask

  task automatic test_pool_full();
    send_beat(mk(1, 5, 2, 0), 4'b0001, 1'b0);
    send_beat(mk(3, 4, 9, -1), 4'b0000, 1'b0);
    send_beat(mk(-8, -2, 7, 7), 4'b0000, 1'b0);
    n_vec++;
    if (m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL pool_no_emit: m_axis_tvalid=%b, required 0", m_tvalid);
    end
    exp_q.push_back({1'b1, mk(5, 9, 0, 8)});
    send_beat(mk(0, -3, 6, 8), 4'b0000, 1'b1);
    drain();
  endtask

  task automatic test_pool_tails();
    // tail at phase 2: second pooled column is vertical-only
    send_beat(mk(1, 2, 3, 4), 4'b0001, 1'b0);
    send_beat(mk(4, 3, 2, 1), 4'b0000, 1'b0);
    exp_q.push_back({1'b1, mk(4, 4, -5, -7)});
    send_beat(mk(-5, -6, -7, -8), 4'b0000, 1'b1);
    drain();
    // tail at phase 1
    send_beat(mk(1, 2, 3, 4), 4'b0001, 1'b0);
    exp_q.push_back({1'b1, mk(9, 4, 0, 0)});
    send_beat(mk(-1, 9, -3, -4), 4'b0000, 1'b1);
    drain();
    // tail at phase 0, then a pass packet right behind it
    exp_q.push_back({1'b1, mk(-1, 10, 0, 0)});
    send_beat(mk(-1, -9, 10, 2), 4'b0001, 1'b1);
    exp_q.push_back({1'b0, mk(7, -7, 100, -128)});
    send_beat(mk(7, -7, 100, -128), 4'b0000, 1'b0);
    exp_q.push_back({1'b1, mk(1, 2, 3, 4)});
    send_beat(mk(1, 2, 3, 4), 4'b0001, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back_random();
    use_model = 1'b1;
    gen_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 64; p++) begin
          int len;
          bit ismax;
          len = $urandom_range(1, 9);
          ismax = ($urandom_range(0, 1) == 1);
          for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            logic [TUW-1:0] u;
            d = {$urandom, $urandom, $urandom, $urandom};
            u = 4'($urandom);
            if (i == 0) u[0] = ismax;
            if ($urandom_range(0, 4) == 0) begin @(posedge aclk); #1; end
            send_beat(d, u, (i == len - 1));
          end
        end
        gen_done = 1'b1;
      end
      begin
        repeat (10) @(posedge aclk);
        #1 m_tready = 1'b0;
        repeat (5) @(posedge aclk);
        #1 m_tready = 1'b1;
        while (!gen_done) begin
          @(posedge aclk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    drain();
    use_model = 1'b0;
  endtask

  task automatic test_reset_midpacket();
    // held output beat is discarded by reset
    m_tready = 1'b0;
    send_beat(mk(11, 12, 13, 14), 4'b0000, 1'b1);
    repeat (2) @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    n_vec++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_drops_output: got v=%b d=%h, required v=0 d=0", m_tvalid, m_tdata);
    end
    model_reset();
    m_tready = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    // reset after two pooled beats
    send_beat(mk(1, 2, 3, 4), 4'b0001, 1'b0);
    send_beat(mk(5, 6, 7, 8), 4'b0000, 1'b0);
    aresetn = 1'b0;
    #1;
    n_vec++;
    if (m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_pool: m_axis_tvalid=%b, required 0", m_tvalid);
    end
    model_reset();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] d;
      d = mk(i, -i, 20 + i, -100 + i);
      exp_q.push_back({(i == 3), d});
      send_beat(d, 4'b0000, (i == 3));
    end
    drain();
    send_beat(mk(1, 5, 2, 0), 4'b0001, 1'b0);
    send_beat(mk(3, 4, 9, -1), 4'b0000, 1'b0);
    send_beat(mk(-8, -2, 7, 7), 4'b0000, 1'b0);
    exp_q.push_back({1'b1, mk(5, 9, 0, 8)});
    send_beat(mk(0, -3, 6, 8), 4'b0000, 1'b1);
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_pool_full();
    test_pool_tails();
    test_back_to_back_random();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
